// File: rtl/systolic_skew_feeder_if.sv
// Vector handshake into the skew feeder FIFO.
interface systolic_skew_feeder_if #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for one edge of an output-stationary PE array.
// Buffers vectors, paces them with the systolic pulse, then drains the skew.
module systolic_skew_feeder #(
    parameter int LANES          = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int PULSE_PERIOD_W = 4
) (
    input  logic                        core_clk,
    input  logic                        resetn,
    systolic_skew_feeder_if.slave       in_if,
    input  logic [PULSE_PERIOD_W-1:0]   cfg_pulse_period,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        underflow,
    output logic                        pulse_systolic_module,
    output logic [LANES-1:0]            lane_valid,
    output logic [LANES*DATA_WIDTH-1:0] lane_data
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int VW  = LANES * DATA_WIDTH;
    localparam int DCW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                    state_q;
    logic [PULSE_PERIOD_W-1:0] cnt_q;
    logic [PULSE_PERIOD_W-1:0] cnt_d;
    logic [PULSE_PERIOD_W-1:0] period_q;
    logic [DCW-1:0]            drain_cnt_q;
    logic                      done_q;
    logic                      underflow_q;

    logic [VW:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic [AW:0] count;
    logic [VW:0] head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        pulse;

    assign count = wr_q - rd_q;
    assign full  = count[AW];
    assign empty = (count == '0);
    assign head  = mem_q[rd_q[AW-1:0]];

    assign in_if.in_ready = resetn & ~full;
    assign push  = in_if.in_valid & in_if.in_ready;
    assign pulse = (state_q != IDLE) && (cnt_q == period_q);
    assign pop   = pulse && (state_q == RUN) && !empty;
    assign cnt_d = (state_q == IDLE || pulse) ? '0
                 : cnt_q + PULSE_PERIOD_W'(1);

    always_ff @(posedge core_clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= {in_if.in_last, in_if.in_data};
        end
    end

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= 1'b0;
            if (push) begin
                wr_q <= wr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        period_q    <= cfg_pulse_period;
                        underflow_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (pulse) begin
                        if (empty) begin
                            underflow_q <= 1'b1;
                        end else if (head[VW]) begin
                            state_q     <= DRAIN;
                            drain_cnt_q <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (pulse) begin
                        if (drain_cnt_q == DRAIN_LAST) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q + DCW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Lane i keeps only its own element, delayed i pulses before the output stage.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] d_q [i+1];
        logic [i:0]            v_q;

        always_ff @(posedge core_clk or negedge resetn) begin
            if (!resetn) begin
                v_q <= '0;
                for (int k = 0; k <= i; k++) begin
                    d_q[k] <= '0;
                end
            end else if (pulse) begin
                v_q[0] <= pop;
                d_q[0] <= pop ? head[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int k = 1; k <= i; k++) begin
                    v_q[k] <= v_q[k-1];
                    d_q[k] <= d_q[k-1];
                end
            end
        end

        assign lane_valid[i] = v_q[i];
        assign lane_data[i*DATA_WIDTH +: DATA_WIDTH] = d_q[i];
    end

    assign busy                  = (state_q != IDLE);
    assign done                  = done_q;
    assign underflow             = underflow_q;
    assign pulse_systolic_module = pulse;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench for systolic_skew_feeder against a queue-based model.
module tb_systolic_skew_feeder;
    localparam int L  = 4;
    localparam int DW = 32;
    localparam int D  = 8;
    localparam int PW = 4;
    localparam int VW = L * DW;
    localparam int OW = 5 + L + VW;

    logic          core_clk = 1'b0;
    logic          resetn   = 1'b1;
    logic [PW-1:0] cfg      = '0;
    logic          start    = 1'b0;
    logic          busy;
    logic          done;
    logic          underflow;
    logic          pulse;
    logic [L-1:0]  lane_valid;
    logic [VW-1:0] lane_data;

    systolic_skew_feeder_if #(.LANES(L), .DATA_WIDTH(DW)) bus ();

    systolic_skew_feeder #(
        .LANES(L),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(D),
        .PULSE_PERIOD_W(PW)
    ) dut (
        .core_clk(core_clk),
        .resetn(resetn),
        .in_if(bus),
        .cfg_pulse_period(cfg),
        .start(start),
        .busy(busy),
        .done(done),
        .underflow(underflow),
        .pulse_systolic_module(pulse),
        .lane_valid(lane_valid),
        .lane_data(lane_data)
    );

    always #5 core_clk = ~core_clk;

    // Model: FIFO queue plus a history of the last L heads (index = pulses ago).
    logic [VW:0]   mq [$];
    logic          hv [L];
    logic [VW-1:0] hd [L];
    bit            m_busy;
    bit            m_drain;
    bit            m_under;
    bit            m_done;
    int            m_j;
    int            m_dcnt;
    int            m_p;
    int            checks = 0;
    int            errors = 0;
    logic [OW-1:0] exp_all;
    logic [VW-1:0] exp_mask;

    function automatic void compute_exp();
        logic [L-1:0]  lv;
        logic [VW-1:0] ld;
        lv       = '0;
        ld       = '0;
        exp_mask = '0;
        for (int i = 0; i < L; i++) begin
            lv[i] = hv[i];
            if (hv[i]) begin
                ld[i*DW +: DW]       = hd[i][i*DW +: DW];
                exp_mask[i*DW +: DW] = '1;
            end
        end
        exp_all = {m_busy && (m_j % (m_p + 1) == m_p), m_busy, m_done,
                   m_under, resetn && (mq.size() < D), lv, ld};
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < L; i++) begin
            hv[i] = 1'b0;
            hd[i] = '0;
        end
        m_busy  = 0;
        m_drain = 0;
        m_under = 0;
        m_done  = 0;
        m_j     = 0;
        m_dcnt  = 0;
        m_p     = 0;
        compute_exp();
    endfunction

    function automatic logic [OW-1:0] obs();
        return {pulse, busy, done, underflow, bus.in_ready,
                lane_valid, lane_data & exp_mask};
    endfunction

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] v;
        for (int i = 0; i < L; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic step();
        bit          pl;
        bit          rdy;
        bit          was_busy;
        logic [VW:0] e;
        if (resetn) begin
            pl       = m_busy && (m_j % (m_p + 1) == m_p);
            rdy      = mq.size() < D;
            was_busy = m_busy;
            m_done   = 0;
            if (pl) begin
                for (int k = L - 1; k > 0; k--) begin
                    hv[k] = hv[k-1];
                    hd[k] = hd[k-1];
                end
                hv[0] = 1'b0;
                hd[0] = '0;
                if (!m_drain) begin
                    if (mq.size() > 0) begin
                        e     = mq.pop_front();
                        hv[0] = 1'b1;
                        hd[0] = e[VW-1:0];
                        if (e[VW]) begin
                            m_drain = 1;
                            m_dcnt  = 0;
                        end
                    end else begin
                        m_under = 1;
                    end
                end else if (m_dcnt == L - 1) begin
                    m_busy  = 0;
                    m_drain = 0;
                    m_done  = 1;
                end else begin
                    m_dcnt++;
                end
            end
            if (bus.in_valid && rdy) mq.push_back({bus.in_last, bus.in_data});
            m_j = m_busy ? m_j + 1 : 0;
            if (!was_busy && start) begin
                m_busy  = 1;
                m_j     = 0;
                m_p     = int'(cfg);
                m_under = 0;
                m_drain = 0;
            end
        end
        @(posedge core_clk);
        #1;
        compute_exp();
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        start        = 1'b0;
        cfg          = '0;
        #1 resetn = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({busy, done, underflow, pulse, lane_valid, bus.in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs act=%b exp=0",
                     {busy, done, underflow, pulse, lane_valid, bus.in_ready});
        end
        repeat (2) @(posedge core_clk);
        #1 resetn = 1'b1;
        compute_exp();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready act=%b exp=1", bus.in_ready);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (obs() !== exp_all) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d act=%h exp=%h", c, obs(), exp_all);
            end
        end
    endtask

    task automatic test_preload();
        int nd = 0;
        for (int c = 0; c < 22; c++) begin
            bus.in_valid = (c < 3);
            bus.in_last  = (c == 2);
            bus.in_data  = rvec();
            start        = (c == 3);
            cfg          = '0;
            step();
            nd += int'(done);
            checks++;
            if (obs() !== exp_all) begin
                errors++;
                $display("FAIL preload cyc=%0d act=%h exp=%h", c, obs(), exp_all);
            end
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("FAIL preload_done_count act=%0d exp=1", nd);
        end
    endtask

    task automatic test_period2();
        int n    = int'($urandom_range(2, 4));
        int prev = -1;
        for (int c = 0; c < 45; c++) begin
            bus.in_valid = (c < n);
            bus.in_last  = (c == n - 1);
            bus.in_data  = rvec();
            start        = (c == n);
            cfg          = PW'(2);
            step();
            checks++;
            if (obs() !== exp_all) begin
                errors++;
                $display("FAIL period2 cyc=%0d act=%h exp=%h", c, obs(), exp_all);
            end
            if (pulse) begin
                if (prev >= 0) begin
                    checks++;
                    if (c - prev !== 3) begin
                        errors++;
                        $display("FAIL period2_gap act=%0d exp=3", c - prev);
                    end
                end
                prev = c;
            end
        end
    endtask

    task automatic test_underflow();
        int p = int'($urandom_range(0, 3));
        for (int c = 0; c < 45; c++) begin
            bus.in_valid = (c == 5);
            bus.in_last  = 1'b1;
            bus.in_data  = rvec();
            start        = (c == 0);
            cfg          = PW'(p);
            step();
            checks++;
            if (obs() !== exp_all) begin
                errors++;
                $display("FAIL underflow cyc=%0d act=%h exp=%h", c, obs(), exp_all);
            end
        end
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky act=%b exp=1", underflow);
        end
    endtask

    task automatic test_fifo_full();
        logic [VW-1:0] v [9];
        int k = 0;
        bit acc;
        for (int i = 0; i < 9; i++) v[i] = rvec();
        for (int c = 0; c < 40; c++) begin
            bus.in_valid = (k < 9);
            bus.in_last  = (k == 8);
            bus.in_data  = (k < 9) ? v[k] : '0;
            start        = (c == 11);
            cfg          = '0;
            if (c == 10) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fifo_full_ready act=%b exp=0", bus.in_ready);
                end
            end
            acc = bus.in_valid && bus.in_ready;
            step();
            if (acc) k++;
            checks++;
            if (obs() !== exp_all) begin
                errors++;
                $display("FAIL fifo_full cyc=%0d act=%h exp=%h", c, obs(), exp_all);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit hit = 0;
        for (int c = 0; c < 60 && !hit; c++) begin
            bus.in_valid = (c < 3);
            bus.in_last  = (c == 1);
            bus.in_data  = rvec();
            start        = (c == 3);
            cfg          = PW'(1);
            step();
            checks++;
            if (obs() !== exp_all) begin
                errors++;
                $display("FAIL mid_drain cyc=%0d act=%h exp=%h", c, obs(), exp_all);
            end
            hit = m_drain && (m_dcnt == 1);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_drain_timeout act=0 exp=1");
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        resetn       = 1'b0;
        #2;
        checks++;
        if ({busy, done, pulse, lane_valid, bus.in_ready} !== '0) begin
            errors++;
            $display("FAIL mid_drain_async act=%b exp=0",
                     {busy, done, pulse, lane_valid, bus.in_ready});
        end
        model_reset();
        step();
        resetn = 1'b1;
        compute_exp();
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = (c == 2);
            bus.in_last  = 1'b1;
            bus.in_data  = rvec();
            start        = (c == 3);
            cfg          = '0;
            step();
            checks++;
            if (obs() !== exp_all) begin
                errors++;
                $display("FAIL post_reset cyc=%0d act=%h exp=%h", c, obs(), exp_all);
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit pushed = 0;
        bit restarted = 0;
        int after = -1;
        for (int c = 0; c < 70; c++) begin
            bus.in_valid = (c == 3) || (c == 4);
            bus.in_last  = (c == 4);
            bus.in_data  = rvec();
            start        = (c == 0) || (c == 6);
            cfg          = (c == 6) ? PW'(3) : PW'(1);
            if (m_drain && !pushed) begin
                bus.in_valid = 1'b1;
                bus.in_last  = 1'b1;
                pushed       = 1;
            end
            if (m_done && !restarted) begin
                start     = 1'b1;
                cfg       = '0;
                restarted = 1;
                after     = c;
            end
            step();
            checks++;
            if (obs() !== exp_all) begin
                errors++;
                $display("FAIL busy_start cyc=%0d act=%h exp=%h", c, obs(), exp_all);
            end
            if (c == after) begin
                checks++;
                if ({underflow, busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL restart act=%b exp=01", {underflow, busy});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW:0] pend [$];
        bit acc;
        for (int j = 0; j < 14; j++) begin
            pend.push_back({($urandom_range(0, 3) == 0) || (j == 13), rvec()});
        end
        for (int c = 0; c < 400; c++) begin
            bus.in_valid = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
            {bus.in_last, bus.in_data} = (pend.size() > 0) ? pend[0] : '0;
            start = ($urandom_range(0, 5) == 0);
            cfg   = PW'($urandom_range(0, 3));
            acc   = bus.in_valid && bus.in_ready;
            step();
            if (acc) void'(pend.pop_front());
            checks++;
            if (obs() !== exp_all) begin
                errors++;
                $display("FAIL b2b cyc=%0d act=%h exp=%h", c, obs(), exp_all);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_period2();
        test_underflow();
        test_fifo_full();
        test_reset_mid_drain();
        test_start_while_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
